riscv_bp_ctrl: RTL and testbench

//  Sequencer/write-port owner for the branch-prediction table (1R1W RAM, 2-bit counters).

---
 rtl/riscv_bp_ctrl_if.sv | 31 +++
 rtl/riscv_bp_ctrl.sv | 137 +++++++++++++
 tb/tb_riscv_bp_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_bp_ctrl_if.sv
// Branch-prediction controller bus: branch-unit update port, flush request,
// GHR/busy status for the fetch side and the BP RAM write port.
interface riscv_bp_ctrl_if #(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10
);
    logic                                    bp_flush;
    logic [XLEN-1:0]                         ex_pc;
    logic [BP_GLOBAL_BITS-1:0]               bu_bp_history;
    logic [1:0]                              bu_bp_predict;
    logic                                    bu_bp_btaken;
    logic                                    bu_bp_update;
    logic [BP_GLOBAL_BITS-1:0]               bp_history;
    logic                                    bp_busy;
    logic                                    ram_we;
    logic [BP_GLOBAL_BITS+BP_LOCAL_BITS-1:0] ram_waddr;
    logic [1:0]                              ram_wdata;

    // Branch unit / pipeline side: issues updates and flushes, observes status.
    modport master (
        output bp_flush, ex_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken, bu_bp_update,
        input  bp_history, bp_busy, ram_we, ram_waddr, ram_wdata
    );

    // Controller side: owns the GHR and the RAM write port.
    modport slave (
        input  bp_flush, ex_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken, bu_bp_update,
        output bp_history, bp_busy, ram_we, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/riscv_bp_ctrl.sv
// Branch-prediction table sequencer and write-port owner.
// INIT sweeps every table entry to INIT_PREDICTION; RUN forwards branch-unit
// updates with the new saturating 2-bit counter and maintains the GHR.
module riscv_bp_ctrl #(
    parameter int         XLEN              = 32,
    parameter int         BP_GLOBAL_BITS    = 2,
    parameter int         BP_LOCAL_BITS     = 10,
    parameter int         BP_LOCAL_BITS_LSB = 2,
    parameter logic [1:0] INIT_PREDICTION   = 2'b01
) (
    input logic            clk,
    input logic            rstn,
    riscv_bp_ctrl_if.slave bp_if
);

    localparam int AW = BP_GLOBAL_BITS + BP_LOCAL_BITS;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    logic [AW-1:0]             r_cnt;
    logic [BP_GLOBAL_BITS-1:0] r_ghr;
    logic                      r_busy;
    logic                      r_we;
    logic [AW-1:0]             r_waddr;
    logic [1:0]                r_wdata;

    state_t                    w_state_nxt;
    logic [AW-1:0]             w_cnt_nxt;
    logic [BP_GLOBAL_BITS-1:0] w_ghr_nxt;
    logic                      w_busy_nxt;
    logic                      w_we_nxt;
    logic [AW-1:0]             w_waddr_nxt;
    logic [1:0]                w_wdata_nxt;

    logic                      w_cnt_last;
    logic [1:0]                w_new_ctr;
    logic [BP_GLOBAL_BITS-1:0] w_ghr_shift;
    logic [BP_LOCAL_BITS-1:0]  w_pc_index;
    logic                      w_unused;

    // Only the index slice of the PC matters; fold the rest away.
    assign w_unused   = ^bp_if.ex_pc;
    assign w_pc_index = bp_if.ex_pc[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS];
    assign w_cnt_last = (r_cnt == {AW{1'b1}});

    // Counter walks 00 <-> 01 <-> 11 <-> 10, saturating at 00 and 10.
    assign w_new_ctr[0] = bp_if.bu_bp_predict[1] ^ bp_if.bu_bp_btaken;
    assign w_new_ctr[1] = (bp_if.bu_bp_predict[1] & ~bp_if.bu_bp_predict[0])
                        | (bp_if.bu_bp_btaken  &  bp_if.bu_bp_predict[0]);

    // Shift-in form works for any GHR width, including a single bit.
    assign w_ghr_shift = (r_ghr << 1) | BP_GLOBAL_BITS'(bp_if.bu_bp_btaken);

    // Next-state and next-output decode for the INIT sweep / RUN forwarding.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ghr_nxt   = r_ghr;
        w_busy_nxt  = r_busy;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        case (r_state)
            S_INIT: begin
                w_ghr_nxt  = '0;
                w_busy_nxt = 1'b1;
                if (bp_if.bp_flush) begin
                    // Restart the sweep; no write is issued on this edge.
                    w_cnt_nxt = '0;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_cnt;
                    w_wdata_nxt = INIT_PREDICTION;
                    w_cnt_nxt   = r_cnt + AW'(1);
                    if (w_cnt_last) begin
                        w_state_nxt = S_RUN;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (bp_if.bp_flush) begin
                    // Flush wins over a simultaneous update.
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                    w_ghr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end else if (bp_if.bu_bp_update) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = {bp_if.bu_bp_history, w_pc_index};
                    w_wdata_nxt = w_new_ctr;
                    w_ghr_nxt   = w_ghr_shift;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
                w_ghr_nxt   = '0;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    // State register; the table RAM itself is cleared by the INIT sweep, not by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_ghr   <= '0;
            r_busy  <= 1'b1;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ghr   <= w_ghr_nxt;
            r_busy  <= w_busy_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign bp_if.bp_history = r_ghr;
    assign bp_if.bp_busy    = r_busy;
    assign bp_if.ram_we     = r_we;
    assign bp_if.ram_waddr  = r_waddr;
    assign bp_if.ram_wdata  = r_wdata;

endmodule

// File: tb/tb_riscv_bp_ctrl.sv
// Directed bench for riscv_bp_ctrl with GLOBAL=2, LOCAL=2, LSB=2 (DEPTH=16).
module tb_riscv_bp_ctrl;

    localparam int XLEN = 32;
    localparam int GB   = 2;
    localparam int LB   = 2;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   writes;

    riscv_bp_ctrl_if #(.XLEN(XLEN), .BP_GLOBAL_BITS(GB), .BP_LOCAL_BITS(LB)) bp_if ();

    riscv_bp_ctrl #(
        .XLEN(XLEN), .BP_GLOBAL_BITS(GB), .BP_LOCAL_BITS(LB),
        .BP_LOCAL_BITS_LSB(2), .INIT_PREDICTION(2'b01)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bp_if(bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [31:0] pc;
        logic [1:0]  hist;
        logic [1:0]  pred;
        logic        taken;
        logic        upd;
        logic        e_we;
        logic [3:0]  e_waddr;
        logic [1:0]  e_wdata;
        logic [1:0]  e_ghr;
        logic        e_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(bp_if.bp_busy),    32'd1);
        check({tag, "_we"},    32'(bp_if.ram_we),     32'd0);
        check({tag, "_waddr"}, 32'(bp_if.ram_waddr),  32'd0);
        check({tag, "_wdata"}, 32'(bp_if.ram_wdata),  32'd0);
        check({tag, "_ghr"},   32'(bp_if.bp_history), 32'd0);
    endtask

    // Full 16-entry sweep starting at the next edge; updates are held active to show they are dropped.
    task automatic sweep(input string tag);
        bp_if.bu_bp_update  = 1'b1;
        bp_if.bu_bp_btaken  = 1'b1;
        bp_if.bu_bp_history = 2'b11;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) bp_if.bu_bp_update = 1'b0;
            tick();
            if (bp_if.ram_we) writes++;
            check({tag, "_we"},    32'(bp_if.ram_we),     32'd1);
            check({tag, "_waddr"}, 32'(bp_if.ram_waddr),  32'(i));
            check({tag, "_wdata"}, 32'(bp_if.ram_wdata),  32'd1);
            check({tag, "_ghr"},   32'(bp_if.bp_history), 32'd0);
            check({tag, "_busy"},  32'(bp_if.bp_busy),    (i == 15) ? 32'd0 : 32'd1);
        end
        bp_if.bu_bp_update = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        writes = 0;
        rstn = 1'b0;
        bp_if.bp_flush      = 1'b0;
        bp_if.ex_pc         = '0;
        bp_if.bu_bp_history = '0;
        bp_if.bu_bp_predict = '0;
        bp_if.bu_bp_btaken  = 1'b0;
        bp_if.bu_bp_update  = 1'b0;

        //        flush pc     hist   pred   t     upd   we    waddr    wdata  ghr    busy
        vecs[0] = '{1'b0, 32'h8,  2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 4'b1010, 2'b11, 2'b01, 1'b0};
        vecs[1] = '{1'b0, 32'h4,  2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 4'b0101, 2'b10, 2'b11, 1'b0};
        vecs[2] = '{1'b0, 32'hC,  2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0101, 2'b10, 2'b11, 1'b0};
        vecs[3] = '{1'b0, 32'hC,  2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 4'b1111, 2'b00, 2'b10, 1'b0};
        vecs[4] = '{1'b0, 32'h0,  2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 4'b0000, 2'b01, 2'b00, 1'b0};
        vecs[5] = '{1'b0, 32'h10, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 4'b1100, 2'b01, 2'b01, 1'b0};
        vecs[6] = '{1'b0, 32'h8,  2'b10, 2'b11, 1'b1, 1'b1, 1'b1, 4'b1010, 2'b10, 2'b11, 1'b0};
        vecs[7] = '{1'b0, 32'h4,  2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 4'b0001, 2'b11, 2'b10, 1'b0};
        vecs[8] = '{1'b1, 32'hC,  2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 4'b0001, 2'b11, 2'b00, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        #2 rstn = 1'b1;

        // Initial sweep after reset release.
        sweep("init");

        // RUN-mode update vectors, ending with flush colliding with an update.
        for (int v = 0; v < 9; v++) begin
            bp_if.bp_flush      = vecs[v].flush;
            bp_if.ex_pc         = vecs[v].pc;
            bp_if.bu_bp_history = vecs[v].hist;
            bp_if.bu_bp_predict = vecs[v].pred;
            bp_if.bu_bp_btaken  = vecs[v].taken;
            bp_if.bu_bp_update  = vecs[v].upd;
            tick();
            check($sformatf("vec%0d_we", v),    32'(bp_if.ram_we),     32'(vecs[v].e_we));
            check($sformatf("vec%0d_waddr", v), 32'(bp_if.ram_waddr),  32'(vecs[v].e_waddr));
            check($sformatf("vec%0d_wdata", v), 32'(bp_if.ram_wdata),  32'(vecs[v].e_wdata));
            check($sformatf("vec%0d_ghr", v),   32'(bp_if.bp_history), 32'(vecs[v].e_ghr));
            check($sformatf("vec%0d_busy", v),  32'(bp_if.bp_busy),    32'(vecs[v].e_busy));
        end
        bp_if.bp_flush     = 1'b0;
        bp_if.bu_bp_update = 1'b0;

        // Sweep that follows the RUN flush.
        sweep("flush_sweep");

        // Flush into INIT, then flush again at sweep address 7.
        bp_if.bp_flush = 1'b1;
        tick();
        check("run_flush_we", 32'(bp_if.ram_we), 32'd0);
        check("run_flush_busy", 32'(bp_if.bp_busy), 32'd1);
        bp_if.bp_flush     = 1'b0;
        bp_if.bu_bp_update = 1'b1;
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bp_if.ram_we) writes++;
            check("part_waddr", 32'(bp_if.ram_waddr), 32'(i));
        end
        bp_if.bp_flush = 1'b1;
        tick();
        if (bp_if.ram_we) writes++;
        check("mid_flush_we", 32'(bp_if.ram_we), 32'd0);
        check("mid_flush_busy", 32'(bp_if.bp_busy), 32'd1);
        bp_if.bp_flush = 1'b0;
        sweep("restart");
        repeat (2) begin
            tick();
            if (bp_if.ram_we) writes++;
        end
        check("restart_write_count", 32'(writes), 32'd24);

        // Build GHR=11 in RUN, then reset asynchronously mid-cycle.
        bp_if.ex_pc         = 32'h4;
        bp_if.bu_bp_history = 2'b00;
        bp_if.bu_bp_predict = 2'b01;
        bp_if.bu_bp_btaken  = 1'b1;
        bp_if.bu_bp_update  = 1'b1;
        tick();
        tick();
        bp_if.bu_bp_update = 1'b0;
        check("pre_reset_ghr", 32'(bp_if.bp_history), 32'd3);
        check("pre_reset_we", 32'(bp_if.ram_we), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_reset_vals("async_rst");
        tick();
        check_reset_vals("held_rst");
        #2 rstn = 1'b1;
        sweep("reinit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
